// File: rtl/bnn_pkg.sv
// Shared constants and types for the binary MLP input path.
package bnn_pkg;

  localparam int IMG_PIXELS = 784;
  localparam int PIXEL_W    = 8;

  typedef enum logic {LD_FILL, LD_FULL} loader_state_t;

  function automatic int beats_per_frame(input int size, input int width);
    return size / width;
  endfunction

endpackage

// File: rtl/bnn_binarizer.sv
// Combinational pixel binarizer: a pixel is 1 when it reaches the threshold.
module bnn_binarizer
  import bnn_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_W
) (
  input  logic [PIXEL_WIDTH-1:0] i_pixel,
  input  logic [PIXEL_WIDTH-1:0] i_threshold,
  output logic                   o_bit
);

  assign o_bit = (i_pixel >= i_threshold);

endmodule

// File: rtl/bnn_input_loader.sv
// Serial pixel stream to INPUT_SIZE-bit binary vector loader for the MLP layer.
// Define BNN_LOADER_PACKED_EN to accept PIXEL_WIDTH pre-binarized pixels per beat.
module bnn_input_loader
  import bnn_pkg::*;
#(
  parameter int INPUT_SIZE  = IMG_PIXELS,
  parameter int PIXEL_WIDTH = PIXEL_W,
  parameter int CNT_WIDTH   = $clog2(INPUT_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] bin_threshold,
  output logic [INPUT_SIZE-1:0]  out_vector,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_err
);

`ifdef BNN_LOADER_PACKED_EN
  localparam int BEATS = beats_per_frame(INPUT_SIZE, PIXEL_WIDTH);

  if (INPUT_SIZE % PIXEL_WIDTH != 0) begin : g_size_check
    $error("bnn_input_loader: INPUT_SIZE must be a multiple of PIXEL_WIDTH");
  end

  logic w_unused_threshold;
  assign w_unused_threshold = ^bin_threshold;
`else
  localparam int BEATS = beats_per_frame(INPUT_SIZE, 1);

  logic w_bit;

  bnn_binarizer #(
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_binarizer (
    .i_pixel    (in_data),
    .i_threshold(bin_threshold),
    .o_bit      (w_bit)
  );
`endif

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BEATS - 1);

  loader_state_t         r_state;
  loader_state_t         w_next_state;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [INPUT_SIZE-1:0] r_vector;
  logic                  r_frame_err;
  logic                  w_accept;
  logic                  w_at_last;
  logic                  w_frame_done;
  logic                  w_frame_bad;

  assign w_accept     = in_valid && in_ready;
  assign w_at_last    = (r_count == LAST_CNT);
  assign w_frame_done = w_accept && w_at_last && in_last;
  // in_last must coincide exactly with the final beat slot, otherwise the frame is dropped
  assign w_frame_bad  = w_accept && (w_at_last != in_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LD_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LD_FILL: if (w_frame_done) w_next_state = LD_FULL;
      LD_FULL: if (out_ready)    w_next_state = LD_FILL;
      default: w_next_state = LD_FILL;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == LD_FILL) && !rst;
    out_valid = (r_state == LD_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_vector    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      if (w_frame_bad || w_frame_done) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_count <= r_count + 1'b1;
      end
      if (w_accept && !w_frame_bad) begin
`ifdef BNN_LOADER_PACKED_EN
        r_vector[r_count*PIXEL_WIDTH +: PIXEL_WIDTH] <= in_data;
`else
        r_vector[r_count] <= w_bit;
`endif
      end
    end
  end

  assign out_vector = r_vector;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_bnn_input_loader.sv
// Self-checking bench for bnn_input_loader: frame-level reference model plus directed frames.
// Honours BNN_LOADER_PACKED_EN to exercise the packed-beat build.
module tb_bnn_input_loader;

  localparam int INPUT_SIZE  = 784;
  localparam int PIXEL_WIDTH = 8;
`ifdef BNN_LOADER_PACKED_EN
  localparam int BITS_PER_BEAT = PIXEL_WIDTH;
`else
  localparam int BITS_PER_BEAT = 1;
`endif
  localparam int BEATS = INPUT_SIZE / BITS_PER_BEAT;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [PIXEL_WIDTH-1:0] in_data = '0;
  logic                   in_valid = 1'b0;
  logic                   in_last = 1'b0;
  logic                   in_ready;
  logic [PIXEL_WIDTH-1:0] bin_threshold = '0;
  logic [INPUT_SIZE-1:0]  out_vector;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic                   frame_err;

  int testsRun = 0;
  int testsFailed = 0;

  // Frame-level reference: bits collected so far in the current frame, last completed vector
  bit                    mFull = 1'b0;
  bit                    mErr = 1'b0;
  bit                    mBits[$];
  int                    mBeats = 0;
  logic [INPUT_SIZE-1:0] mVec = '0;
  logic [INPUT_SIZE-1:0] snapshot;

  bnn_input_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .bin_threshold(bin_threshold),
    .out_vector   (out_vector),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkVector(input string name, input logic [INPUT_SIZE-1:0] act,
                             input logic [INPUT_SIZE-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mFull = 1'b0;
    mErr = 1'b0;
    mBits.delete();
    mBeats = 0;
    mVec = '0;
  endtask

  task automatic modelStep(input logic v, input logic [PIXEL_WIDTH-1:0] d, input logic l,
                           input logic r, input logic [PIXEL_WIDTH-1:0] thr);
    mErr = 1'b0;
    if (mFull) begin
      if (r) mFull = 1'b0;
    end else if (v) begin
      if (l != (mBeats == BEATS - 1)) begin
        mErr = 1'b1;
        mBits.delete();
        mBeats = 0;
      end else begin
`ifdef BNN_LOADER_PACKED_EN
        for (int j = 0; j < PIXEL_WIDTH; j++) mBits.push_back(d[j]);
`else
        mBits.push_back(d >= thr);
`endif
        mBeats++;
        if (l) begin
          for (int i = 0; i < INPUT_SIZE; i++) mVec[i] = mBits[i];
          mBits.delete();
          mBeats = 0;
          mFull = 1'b1;
        end
      end
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the model advances on the same edge as the DUT.
  task automatic applyStimulus(input logic v, input logic [PIXEL_WIDTH-1:0] d, input logic l,
                               input logic r, input logic [PIXEL_WIDTH-1:0] thr);
    in_valid = v;
    in_data = d;
    in_last = l;
    out_ready = r;
    bin_threshold = thr;
    @(posedge clk);
    if (!rst) modelStep(v, d, l, r, thr);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, bin_threshold);
  endtask

  task automatic sendBeats(input int n, input int lastAt, input logic [PIXEL_WIDTH-1:0] thr);
    for (int k = 0; k < n; k++) begin
`ifdef BNN_LOADER_PACKED_EN
      applyStimulus(1'b1, 8'hA5, (k == lastAt), 1'b0, PIXEL_WIDTH'(k * 37));
`else
      applyStimulus(1'b1, PIXEL_WIDTH'(k % 256), (k == lastAt), 1'b0, thr);
`endif
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic releaseVector();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, bin_threshold);
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    modelReset();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    checkOutput("out_valid", 32'(out_valid), 32'(mFull));
    checkOutput("in_ready", 32'(in_ready), 32'(!mFull && !rst));
    checkOutput("frame_err", 32'(frame_err), 32'(mErr));
    if (rst) checkVector("reset_vector", out_vector, '0);
    else if (mFull) checkVector("out_vector", out_vector, mVec);
  end

  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

`ifdef BNN_LOADER_PACKED_EN
    sendBeats(BEATS, BEATS - 1, 8'd0);
    checkOutput("packed_valid", 32'(out_valid), 32'd1);
    checkOutput("packed_low_byte", 32'(out_vector[7:0]), 32'hA5);
    checkVector("packed_pattern", out_vector, {98{8'hA5}});
    releaseVector();
    idle(2);
    sendBeats(20, 19, 8'd0);
    checkOutput("packed_early_last_err", 32'(frame_err), 32'd1);
    idle(2);
    sendBeats(BEATS, BEATS - 1, 8'd0);
    checkVector("packed_after_err", out_vector, {98{8'hA5}});
    releaseVector();
`else
    sendBeats(BEATS, BEATS - 1, 8'd128);
    checkOutput("frame1_valid_latency", 32'(out_valid), 32'd1);
    checkOutput("frame1_ones", 32'($countones(out_vector)), 32'd384);
    checkOutput("frame1_bit127", 32'(out_vector[127]), 32'd0);
    checkOutput("frame1_bit128", 32'(out_vector[128]), 32'd1);
    checkOutput("frame1_bit767", 32'(out_vector[767]), 32'd1);
    checkOutput("frame1_bit783", 32'(out_vector[783]), 32'd0);

    snapshot = out_vector;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 8'd128);
    checkVector("hold_vector", out_vector, snapshot);
    checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1, 8'd128);
    checkOutput("hold_release_valid", 32'(out_valid), 32'd0);
    checkOutput("hold_release_ready", 32'(in_ready), 32'd1);
    idle(2);

    sendBeats(101, 100, 8'd128);
    checkOutput("early_last_err", 32'(frame_err), 32'd1);
    idle(1);
    checkOutput("early_last_err_pulse", 32'(frame_err), 32'd0);
    checkOutput("early_last_no_valid", 32'(out_valid), 32'd0);
    sendBeats(BEATS, BEATS - 1, 8'd0);
    checkOutput("thr0_all_ones", 32'($countones(out_vector)), 32'd784);
    releaseVector();
    idle(1);

    sendBeats(BEATS, -1, 8'd128);
    checkOutput("missing_last_err", 32'(frame_err), 32'd1);
    checkOutput("missing_last_no_valid", 32'(out_valid), 32'd0);
    sendBeats(BEATS, BEATS - 1, 8'd128);
    checkOutput("after_missing_ones", 32'($countones(out_vector)), 32'd384);
    releaseVector();
    idle(1);

    sendBeats(400, -1, 8'd128);
    doReset(3);
    sendBeats(BEATS, BEATS - 1, 8'd200);
    checkOutput("post_reset_valid", 32'(out_valid), 32'd1);
    checkOutput("post_reset_ones", 32'($countones(out_vector)), 32'd168);
    checkOutput("post_reset_bit200", 32'(out_vector[200]), 32'd1);
    checkOutput("post_reset_bit199", 32'(out_vector[199]), 32'd0);
    releaseVector();
`endif
    idle(3);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
